// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC, memory address, read wait and valid/ready slot to decode.
// Define FETCH_ALIGN_CHECK_EN to halt with FetchErr on a misaligned redirect.
module instruction_fetch_unit #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int unsigned RD_CYCLES = 1,
  parameter logic [63:0] MEM_BYTES = 64'h64
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic [63:0] InstAddr,
  input  logic [31:0] InstData,
  output logic [31:0] Instr,
  output logic [63:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BrTaken,
  input  logic [63:0] BrPC,
  input  logic [63:0] BrImm,
  output logic        Halted,
  output logic        FetchErr
);

  localparam int CW = (RD_CYCLES > 1) ? $clog2(RD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(RD_CYCLES - 1);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    HALT
  } state_t;

  state_t        state;
  logic [63:0]   pc;
  logic [CW-1:0] cnt;
  logic          ferr;
  logic [63:0]   sum;
  logic [63:0]   target;
  logic          bad_align;
  logic          redirect;
  logic          pc_hi;
  logic          tgt_hi;

  assign sum = BrPC + {BrImm[61:0], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign target    = sum;
  assign bad_align = |sum[1:0];
  assign FetchErr  = ferr;
`else
  assign target    = sum & ~64'h3;
  assign bad_align = 1'b0;
  assign FetchErr  = 1'b0;
`endif

  // an error latches fetch off; only reset recovers
  assign redirect = BrTaken & ~ferr;
  assign pc_hi    = pc >= MEM_BYTES;
  assign tgt_hi   = target >= MEM_BYTES;
  assign InstAddr = pc;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      cnt        <= '0;
      ferr       <= 1'b0;
      Instr      <= '0;
      InstrPC    <= '0;
      InstrValid <= 1'b0;
      Halted     <= 1'b0;
    end else if (redirect) begin
      InstrValid <= 1'b0;
      cnt        <= '0;
      if (bad_align) begin
        state  <= HALT;
        Halted <= 1'b1;
        ferr   <= 1'b1;
      end else begin
        pc     <= target;
        state  <= tgt_hi ? HALT : FETCH;
        Halted <= tgt_hi;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (pc_hi) begin
            state  <= HALT;
            Halted <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            Instr      <= InstData;
            InstrPC    <= pc;
            InstrValid <= 1'b1;
            pc         <= pc + 64'd4;
            cnt        <= '0;
            state      <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (InstrReady) begin
            InstrValid <= 1'b0;
            state      <= pc_hi ? HALT : FETCH;
            Halted     <= pc_hi;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: memory model plus transfer scoreboard.
module tb_instruction_fetch_unit;

  logic        CLK;
  logic        Reset;
  logic [63:0] InstAddr;
  logic [31:0] InstData;
  logic [31:0] Instr;
  logic [63:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady;
  logic        BrTaken;
  logic [63:0] BrPC;
  logic [63:0] BrImm;
  logic        Halted;
  logic        FetchErr;

  instruction_fetch_unit dut (
    .CLK(CLK),
    .Reset(Reset),
    .InstAddr(InstAddr),
    .InstData(InstData),
    .Instr(Instr),
    .InstrPC(InstrPC),
    .InstrValid(InstrValid),
    .InstrReady(InstrReady),
    .BrTaken(BrTaken),
    .BrPC(BrPC),
    .BrImm(BrImm),
    .Halted(Halted),
    .FetchErr(FetchErr)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem [0:24];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          xfer_n = 0;
  int          first_cyc = 0;
  int          last_cyc = 0;
  bit          found;
  int          n;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  assign InstData = (InstAddr < 64'h64) ? mem[InstAddr[6:2]] : 'x;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(logic [63:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = mem[pc[6:2]];
    q.push_back(e);
  endtask

  task automatic wait_valid(string tag);
    bit f = 0;
    for (int i = 0; i < 20 && !f; i++) begin
      tick();
      f = InstrValid;
    end
    chk(tag, 64'(f), 64'd1);
  endtask

  always @(negedge CLK) begin
    if (!Reset && InstrValid && InstrReady) begin
      chk("xfer_queue", 64'(q.size() != 0), 64'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        chk("xfer_pc", InstrPC, e.pc);
        chk("xfer_ins", 64'(Instr), 64'(e.ins));
      end
      if (xfer_n == 0) first_cyc = cyc;
      last_cyc = cyc;
      xfer_n++;
    end
  end

  initial begin
    for (int i = 0; i < 25; i++) mem[i] = 32'h9100_0000 | 32'(i);
    mem[0]  = 32'hF84003E9;
    mem[1]  = 32'hF84083EA;
    mem[2]  = 32'hF84103EB;
    mem[5]  = 32'hAA0B014A;
    mem[8]  = 32'h8B0901AD;
    mem[10] = 32'h17FFFFFD;
    mem[24] = 32'hF841C3EA;

    Reset      = 1'b1;
    InstrReady = 1'b0;
    BrTaken    = 1'b0;
    BrPC       = '0;
    BrImm      = '0;
    repeat (2) tick();
    chk("rst_instr", 64'(Instr), 64'h0);
    chk("rst_ipc", InstrPC, 64'h0);
    chk("rst_vld", 64'(InstrValid), 64'h0);
    chk("rst_halt", 64'(Halted), 64'h0);
    chk("rst_err", 64'(FetchErr), 64'h0);
    chk("rst_addr", InstAddr, 64'h0);

    // straight-line fetch, one word per two edges
    push(64'h0);
    push(64'h4);
    InstrReady = 1'b1;
    Reset      = 1'b0;
    found      = 0;
    n          = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      n++;
      if (InstrValid && InstrPC == 64'h8) found = 1;
    end
    InstrReady = 1'b0;
    chk("t1_found", 64'(found), 64'd1);
    chk("t1_edges", 64'(n), 64'd5);
    chk("t1_queue", 64'(q.size()), 64'd0);

    // stall holds the slot
    repeat (5) begin
      tick();
      chk("t2_ins", 64'(Instr), 64'hF84103EB);
      chk("t2_addr", InstAddr, 64'hC);
      chk("t2_vld", 64'(InstrValid), 64'd1);
    end

    // backward branch drops the held word
    xfer_n  = 0;
    BrPC    = 64'h28;
    BrImm   = 64'hFFFF_FFFF_FFFF_FFFE;
    BrTaken = 1'b1;
    tick();
    BrTaken = 1'b0;
    chk("t3_vld", 64'(InstrValid), 64'd0);
    chk("t3_addr", InstAddr, 64'h20);
    for (int a = 'h20; a <= 'h60; a += 4) push(64'(a));
    InstrReady = 1'b1;

    // free run to the ceiling
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      if (Halted) found = 1;
    end
    chk("t4_halt", 64'(found), 64'd1);
    chk("t4_addr", InstAddr, 64'h64);
    chk("t4_vld", 64'(InstrValid), 64'd0);
    repeat (3) tick();
    chk("t4_vld_hold", 64'(InstrValid), 64'd0);
    chk("t4_halt_hold", 64'(Halted), 64'd1);
    chk("t4_queue", 64'(q.size()), 64'd0);
    chk("t4_count", 64'(xfer_n), 64'd17);
    chk("t4_span", 64'(last_cyc - first_cyc), 64'd32);

    // redirect out of HALT, then branch on the handshake edge
    BrPC  = 64'h0;
    BrImm = 64'h0;
    push(64'h0);
    BrTaken = 1'b1;
    tick();
    BrTaken = 1'b0;
    chk("t5_unhalt", 64'(Halted), 64'd0);
    wait_valid("t5_wait0");
    BrPC    = 64'h8;
    BrImm   = 64'h3;
    BrTaken = 1'b1;
    tick();
    BrTaken = 1'b0;
    chk("t5_vld", 64'(InstrValid), 64'd0);
    chk("t5_addr", InstAddr, 64'h14);
    chk("t5_queue", 64'(q.size()), 64'd0);
    wait_valid("t5_wait14");
    InstrReady = 1'b0;
    chk("t5_ipc", InstrPC, 64'h14);
    chk("t5_ins", 64'(Instr), 64'hAA0B014A);

    // misaligned redirect target
    BrPC    = 64'h2A;
    BrImm   = 64'h0;
    BrTaken = 1'b1;
    tick();
    BrTaken = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    chk("t6_halt", 64'(Halted), 64'd1);
    chk("t6_err", 64'(FetchErr), 64'd1);
    chk("t6_addr", InstAddr, 64'h18);
    chk("t6_vld", 64'(InstrValid), 64'd0);
    BrPC    = 64'h0;
    BrTaken = 1'b1;
    tick();
    BrTaken = 1'b0;
    chk("t6_sticky_halt", 64'(Halted), 64'd1);
    chk("t6_sticky_err", 64'(FetchErr), 64'd1);
    chk("t6_sticky_addr", InstAddr, 64'h18);
`else
    chk("t6_addr", InstAddr, 64'h28);
    chk("t6_err", 64'(FetchErr), 64'd0);
    chk("t6_halt", 64'(Halted), 64'd0);
    chk("t6_vld", 64'(InstrValid), 64'd0);
    wait_valid("t6_wait");
    chk("t6_ipc", InstrPC, 64'h28);
    chk("t6_ins", 64'(Instr), 64'h17FFFFFD);
`endif

    // async reset while a word is held
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    wait_valid("t7_wait");
    chk("t7_ipc", InstrPC, 64'h0);
    #2;
    Reset = 1'b1;
    #1;
    chk("t7_vld", 64'(InstrValid), 64'd0);
    chk("t7_instr", 64'(Instr), 64'h0);
    chk("t7_ipc0", InstrPC, 64'h0);
    chk("t7_err", 64'(FetchErr), 64'd0);
    chk("t7_halt", 64'(Halted), 64'd0);
    tick();
    Reset = 1'b0;
    tick();
    chk("t7_queue", 64'(q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
